// File: rtl/charrom_arbiter_if.sv
// Bundle of the two requester handshakes, the character-ROM port and the tagged response.
// The slave modport is the arbiter side; master is the requester/ROM side.
interface charrom_arbiter_if;
  localparam int unsigned SYM_W   = 2;
  localparam int unsigned COORD_W = 5;
  localparam int unsigned DATA_W  = 3;

  logic               req0_valid;
  logic [SYM_W-1:0]   req0_sym;
  logic [COORD_W-1:0] req0_x;
  logic [COORD_W-1:0] req0_y;
  logic               req0_ready;

  logic               req1_valid;
  logic [SYM_W-1:0]   req1_sym;
  logic [COORD_W-1:0] req1_x;
  logic [COORD_W-1:0] req1_y;
  logic               req1_ready;

  logic [SYM_W-1:0]   rom_sym;
  logic [COORD_W-1:0] rom_xaddr;
  logic [COORD_W-1:0] rom_yaddr;
  logic [DATA_W-1:0]  rom_data;

  logic               rsp0_valid;
  logic               rsp1_valid;
  logic [DATA_W-1:0]  rsp_data;

  modport slave (
    input  req0_valid, req0_sym, req0_x, req0_y,
    input  req1_valid, req1_sym, req1_x, req1_y,
    input  rom_data,
    output req0_ready, req1_ready,
    output rom_sym, rom_xaddr, rom_yaddr,
    output rsp0_valid, rsp1_valid, rsp_data
  );

  modport master (
    output req0_valid, req0_sym, req0_x, req0_y,
    output req1_valid, req1_sym, req1_x, req1_y,
    output rom_data,
    input  req0_ready, req1_ready,
    input  rom_sym, rom_xaddr, rom_yaddr,
    input  rsp0_valid, rsp1_valid, rsp_data
  );
endinterface

// File: rtl/charrom_arbiter.sv
// Two-requester arbiter for the character-ROM port: fixed priority to the pixel path with
// a starvation force-grant for the overlay. Optional counters under CHARROM_ARBITER_STATS_EN.
module charrom_arbiter #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  charrom_arbiter_if.slave   bus
`ifdef CHARROM_ARBITER_STATS_EN
  ,
  output logic [15:0]        stat_grant0,
  output logic [15:0]        stat_grant1,
  output logic [15:0]        stat_force1
`endif
);

  localparam int unsigned        DATA_W     = 3;
  localparam logic [WAIT_W-1:0]  MAX_WAIT_V = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              force1;
  logic              grant0;
  logic              grant1;

  // Grant decision and ROM address mux; the mux falls back to requester 0 when idle.
  always_comb begin
    force1         = bus.req1_valid && (wait_cnt >= MAX_WAIT_V);
    grant1         = bus.req1_valid && (force1 || !bus.req0_valid);
    grant0         = bus.req0_valid && !grant1;
    bus.req0_ready = grant0;
    bus.req1_ready = grant1;
    bus.rom_sym    = grant1 ? bus.req1_sym : bus.req0_sym;
    bus.rom_xaddr  = grant1 ? bus.req1_x   : bus.req0_x;
    bus.rom_yaddr  = grant1 ? bus.req1_y   : bus.req0_y;
  end

  // Starvation count: any gap in req1_valid or a grant forfeits accumulated credit.
  always_comb begin
    wait_nxt = wait_cnt;
    if (!bus.req1_valid || grant1) begin
      wait_nxt = '0;
    end else if (wait_cnt < MAX_WAIT_V) begin
      wait_nxt = wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_nxt;
    end
  end

  // One-cycle response stage; data holds when no grant so the bus stays quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      bus.rsp_data   <= '0;
    end else begin
      bus.rsp0_valid <= grant0;
      bus.rsp1_valid <= grant1;
      if (grant0 || grant1) begin
        bus.rsp_data <= DATA_W'(bus.rom_data);
      end
    end
  end

`ifdef CHARROM_ARBITER_STATS_EN
  // Saturating event counters; stat_force1 counts cycles where requester 0 was pre-empted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grant0 <= '0;
      stat_grant1 <= '0;
      stat_force1 <= '0;
    end else begin
      if (grant0 && (stat_grant0 != 16'hFFFF)) begin
        stat_grant0 <= stat_grant0 + 16'd1;
      end
      if (grant1 && (stat_grant1 != 16'hFFFF)) begin
        stat_grant1 <= stat_grant1 + 16'd1;
      end
      if (force1 && bus.req0_valid && (stat_force1 != 16'hFFFF)) begin
        stat_force1 <= stat_force1 + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_charrom_arbiter.sv
// Directed bench for charrom_arbiter: reset, single requester, contention/force-grant,
// credit loss on valid drop, and the optional statistics counters.
module tb_charrom_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_bad;

  charrom_arbiter_if bus ();

`ifdef CHARROM_ARBITER_STATS_EN
  logic [15:0] stat_grant0;
  logic [15:0] stat_grant1;
  logic [15:0] stat_force1;
`endif

  charrom_arbiter #(.MAX_WAIT(15), .WAIT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef CHARROM_ARBITER_STATS_EN
    ,
    .stat_grant0 (stat_grant0),
    .stat_grant1 (stat_grant1),
    .stat_force1 (stat_force1)
`endif
  );

  // Model ROM: XOR of the four 3-bit slices of the 12-bit address {sym,y,x}.
  function automatic logic [2:0] rom_model(input logic [11:0] a);
    return a[2:0] ^ a[5:3] ^ a[8:6] ^ a[11:9];
  endfunction

  assign bus.rom_data = rom_model({bus.rom_sym, bus.rom_yaddr, bus.rom_xaddr});

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic v1);
    bus.req0_valid = v0;
    bus.req1_valid = v1;
  endtask

  // Requester 0 lookup 0x925 -> colour 1; requester 1 lookup 0x4E3 -> colour 6.
  localparam logic [2:0] D0 = 3'd1;
  localparam logic [2:0] D1 = 3'd6;

  initial begin
    int g1_seen;
    n_checks = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    drive(1'b0, 1'b0);
    bus.req0_sym = 2'd2; bus.req0_x = 5'd5; bus.req0_y = 5'd9;
    bus.req1_sym = 2'd1; bus.req1_x = 5'd3; bus.req1_y = 5'd7;

    // Reset state
    #3;
    check("rst_rsp0", 32'(bus.rsp0_valid), 32'd0);
    check("rst_rsp1", 32'(bus.rsp1_valid), 32'd0);
    check("rst_data", 32'(bus.rsp_data), 32'd0);
    check("model_0x925", 32'(rom_model(12'h925)), 32'(D0));
    check("model_0x4e3", 32'(rom_model(12'h4E3)), 32'(D1));
    tick();
    rst_n = 1'b1;
    tick();

    // Grant in flight, then asynchronous reset mid-cycle drops it
    drive(1'b1, 1'b0);
    #1;
    check("pre_rst_ready0", 32'(bus.req0_ready), 32'd1);
    tick();
    check("pre_rst_rsp0", 32'(bus.rsp0_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rsp0", 32'(bus.rsp0_valid), 32'd0);
    check("async_data", 32'(bus.rsp_data), 32'd0);
    check("rst_ready0_comb", 32'(bus.req0_ready), 32'd1);
    drive(1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_rsp0", 32'(bus.rsp0_valid), 32'd0);
    check("post_rst_rsp1", 32'(bus.rsp1_valid), 32'd0);

    // Requester 0 only, held for three cycles
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0);
      #1;
      check($sformatf("r0_addr_%0d", k),
            32'({bus.rom_sym, bus.rom_yaddr, bus.rom_xaddr}), 32'h925);
      check($sformatf("r0_ready1_%0d", k), 32'(bus.req1_ready), 32'd0);
      tick();
      check($sformatf("r0_rsp0_%0d", k), 32'(bus.rsp0_valid), 32'd1);
      check($sformatf("r0_data_%0d", k), 32'(bus.rsp_data), 32'(D0));
    end
    drive(1'b0, 1'b0);
    tick();
    check("r0_idle_rsp0", 32'(bus.rsp0_valid), 32'd0);
    check("r0_idle_hold", 32'(bus.rsp_data), 32'(D0));

    // Fresh reset so the stats reflect only the contention run
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Continuous contention: requester 1 wins every 16th cycle
    g1_seen = 0;
    for (int k = 0; k < 64; k++) begin
      logic exp1;
      exp1 = ((k % 16) == 15);
      drive(1'b1, 1'b1);
      #1;
      check($sformatf("ct_ready1_%0d", k), 32'(bus.req1_ready), 32'(exp1));
      check($sformatf("ct_ready0_%0d", k), 32'(bus.req0_ready), 32'(!exp1));
      check($sformatf("ct_sym_%0d", k), 32'(bus.rom_sym), exp1 ? 32'd1 : 32'd2);
      if (bus.req1_ready) g1_seen++;
      tick();
      check($sformatf("ct_rsp1_%0d", k), 32'(bus.rsp1_valid), 32'(exp1));
      check($sformatf("ct_rsp0_%0d", k), 32'(bus.rsp0_valid), 32'(!exp1));
      check($sformatf("ct_data_%0d", k), 32'(bus.rsp_data), exp1 ? 32'(D1) : 32'(D0));
    end
    check("ct_grant1_total", 32'(g1_seen), 32'd4);
`ifdef CHARROM_ARBITER_STATS_EN
    check("stat_grant0", 32'(stat_grant0), 32'd60);
    check("stat_grant1", 32'(stat_grant1), 32'd4);
    check("stat_force1", 32'(stat_force1), 32'd4);
`endif

    // Requester 1 alone: granted every cycle
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1);
      #1;
      check($sformatf("r1_ready1_%0d", k), 32'(bus.req1_ready), 32'd1);
      check($sformatf("r1_addr_%0d", k),
            32'({bus.rom_sym, bus.rom_yaddr, bus.rom_xaddr}), 32'h4E3);
      tick();
      check($sformatf("r1_rsp1_%0d", k), 32'(bus.rsp1_valid), 32'd1);
      check($sformatf("r1_rsp0_%0d", k), 32'(bus.rsp0_valid), 32'd0);
      check($sformatf("r1_data_%0d", k), 32'(bus.rsp_data), 32'(D1));
    end

    // Requester 1 waits 10 cycles, drops valid once, then needs a full 15 again
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b1);
      #1;
      check($sformatf("w10_ready1_%0d", k), 32'(bus.req1_ready), 32'd0);
      tick();
    end
    drive(1'b1, 1'b0);
    #1;
    check("drop_ready0", 32'(bus.req0_ready), 32'd1);
    tick();
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 1'b1);
      #1;
      check($sformatf("re_ready1_%0d", k), 32'(bus.req1_ready), 32'(k == 15));
      tick();
    end

    drive(1'b0, 1'b0);
    tick();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
